// File: rtl/rv32_pkg.sv
// Shared rv32 pipeline definitions: major opcodes, writeback classes,
// interlock FSM states and small decode helpers.
package rv32_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LINK,
        WB_LOAD
    } wb_class_e;

    typedef enum logic {
        IDLE,
        LD_WAIT
    } state_e;

    // Where a producer's register result comes from, judged by its opcode.
    function automatic wb_class_e wb_class(input logic [6:0] opc);
        case (opc)
            OP, OP_IMM, LUI, AUIPC: return WB_ALU;
            JAL, JALR:              return WB_LINK;
            LOAD:                   return WB_LOAD;
            default:                return WB_NONE;
        endcase
    endfunction

    // U-type and JAL carry no rs1 field.
    function automatic logic uses_rs1(input logic [6:0] opc);
        return !(opc == LUI || opc == AUIPC || opc == JAL);
    endfunction

    // Only R-type, stores and branches read rs2.
    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OP || opc == STORE || opc == BRANCH);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_src_match.sv
// Compares one decode-stage source register against the EXE and ACC
// producers and reports which one (if any) should supply its value.
module src_match
    import rv32_pkg::*;
(
    input  logic      [4:0] src,
    input  logic            used,
    input  logic            exe_valid,
    input  logic      [4:0] exe_rd,
    input  wb_class_e       exe_cls,
    input  logic            acc_valid,
    input  logic      [4:0] acc_rd,
    input  wb_class_e       acc_cls,
    output logic            hit,
    output logic            sel_exe,
    output logic            load_hit
);

    logic exe_hit;
    logic acc_hit;

    // x0 is never forwarded; EXE wins over ACC because it is the younger writer.
    always_comb begin
        exe_hit  = used && exe_valid && (exe_cls != WB_NONE) &&
                   (exe_rd != 5'd0) && (exe_rd == src);
        acc_hit  = used && acc_valid && (acc_cls != WB_NONE) &&
                   (acc_rd != 5'd0) && (acc_rd == src);
        hit      = exe_hit || acc_hit;
        sel_exe  = exe_hit;
        load_hit = exe_hit && (exe_cls == WB_LOAD);
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use interlock for the DE -> EXE -> ACC pipe.
// Forward data is registered so it lines up with the consumer in EXE.
module fwd_hazard_unit
    import rv32_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             instr_de,
    input  logic                    valid_de,
    input  logic [31:0]             instr_exe,
    input  logic                    valid_exe,
    input  logic [XLEN-1:0]         alu_out_exe,
    input  logic [XLEN-1:0]         pc_exe,
    input  logic [31:0]             instr_acc,
    input  logic                    valid_acc,
    input  logic [XLEN-1:0]         alu_out_acc,
    input  logic [XLEN-1:0]         dmem_out_acc,
    input  logic                    dmem_valid_acc,
    input  logic [XLEN-1:0]         pc_4_acc,
    input  logic                    flush,
    output logic                    stall,
    output logic                    bubble_exe,
    output logic [NUM_SRC-1:0]      hazard,
    output logic [NUM_SRC*XLEN-1:0] fwd_data,
    output logic [CNT_W-1:0]        stall_cycles
);

    wb_class_e exe_cls;
    wb_class_e acc_cls;
    logic      use_rs1;
    logic      use_rs2;
    logic      unused_bits;

    logic [XLEN-1:0] exe_value;
    logic [XLEN-1:0] acc_value;

    logic [NUM_SRC-1:0]           hit;
    logic [NUM_SRC-1:0]           sel_exe;
    logic [NUM_SRC-1:0]           load_hit;
    logic [NUM_SRC-1:0]           fwd_hit;
    logic [NUM_SRC-1:0][XLEN-1:0] lane_val;
    logic [NUM_SRC-1:0]           ld_mask;
    logic                         ld_use;

    state_e state;
    state_e next_state;

    assign unused_bits = ^{instr_de[31:25], instr_de[14:7],
                           instr_exe[31:12], instr_acc[31:12]};

    // Decode producer classes, consumer source usage and producer values.
    always_comb begin
        exe_cls   = wb_class(instr_exe[6:0]);
        acc_cls   = wb_class(instr_acc[6:0]);
        use_rs1   = valid_de && uses_rs1(instr_de[6:0]);
        use_rs2   = valid_de && uses_rs2(instr_de[6:0]);
        exe_value = (exe_cls == WB_LINK) ? pc_exe + XLEN'(4) : alu_out_exe;
        case (acc_cls)
            WB_LINK: acc_value = pc_4_acc;
            WB_LOAD: acc_value = dmem_out_acc;
            default: acc_value = alu_out_acc;
        endcase
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [4:0] src_reg;
        logic       src_used;

        assign src_reg  = (i == 0) ? instr_de[19:15] : instr_de[24:20];
        assign src_used = (i == 0) ? use_rs1 : use_rs2;

        src_match u_match (
            .src       (src_reg),
            .used      (src_used),
            .exe_valid (valid_exe),
            .exe_rd    (instr_exe[11:7]),
            .exe_cls   (exe_cls),
            .acc_valid (valid_acc),
            .acc_rd    (instr_acc[11:7]),
            .acc_cls   (acc_cls),
            .hit       (hit[i]),
            .sel_exe   (sel_exe[i]),
            .load_hit  (load_hit[i])
        );

        // A load being waited on supplies its returning data; otherwise the
        // normal EXE/ACC selection applies.
        assign fwd_hit[i]  = hit[i] || ((state == LD_WAIT) && ld_mask[i]);
        assign lane_val[i] = ((state == LD_WAIT) && ld_mask[i]) ? dmem_out_acc :
                             sel_exe[i] ? exe_value : acc_value;
    end

    assign ld_use = |load_hit;

    // Interlock FSM next state and the combinational stall; flush overrides all.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_use) begin
                        stall      = 1'b1;
                        next_state = LD_WAIT;
                    end
                end
                LD_WAIT: begin
                    if (dmem_valid_acc) begin
                        next_state = IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // State, bubble, forward registers and the saturating stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ld_mask      <= '0;
            bubble_exe   <= 1'b0;
            hazard       <= '0;
            fwd_data     <= '0;
            stall_cycles <= '0;
        end else begin
            state      <= next_state;
            bubble_exe <= flush || stall;
            if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if ((state == IDLE) && stall) begin
                ld_mask <= load_hit;
            end
            if (flush || stall) begin
                hazard <= '0;
            end else begin
                hazard <= fwd_hit;
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (fwd_hit[i]) begin
                        fwd_data[i*XLEN +: XLEN] <= lane_val[i];
                    end
                end
            end
        end
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised operand-forwarding and load-use interlock unit for the rv32 pipeline (DE -> EXE -> ACC). It compares source registers in DE against destinations in EXE and ACC, classifies each producer's writeback source, and registers per-operand forward data so it enters EXE alongside the consuming instruction. A small FSM holds the front end while a load in flight has not yet returned data. Versus the previous unit it adds:
- x0 suppression
- valid and flush qualification
- variable memory latency
- a stall-cycle counter

Parameters:
XLEN, 32, datapath width of operands and forward data
NUM_SRC, 2, source operands checked per instruction (1 = rs1 only, 2 = rs1 and rs2)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
instr_de  in  32  instruction in decode
valid_de  in  1  decode slot holds a real instruction
instr_exe  in  32  instruction in execute
valid_exe  in  1  execute slot valid
alu_out_exe  in  XLEN  ALU result of EXE instruction
pc_exe  in  XLEN  PC of EXE instruction
instr_acc  in  32  instruction in memory-access stage
valid_acc  in  1  ACC slot valid
alu_out_acc  in  XLEN  ALU result carried in ACC
dmem_out_acc  in  XLEN  load data in ACC
dmem_valid_acc  in  1  dmem_out_acc is valid this cycle
pc_4_acc  in  XLEN  link value (PC+4) carried in ACC
flush  in  1  branch/jump redirect; kills DE and EXE
stall  out  1  hold PC and DE register (combinational)
bubble_exe  out  1  registered; EXE receives a NOP next cycle
hazard  out  NUM_SRC  registered; bit i = operand i uses fwd_data
fwd_data  out  NUM_SRC*XLEN  registered; operand i at [i*XLEN +: XLEN]
stall_cycles  out  CNT_W  saturating count of cycles with stall=1

Behaviour:
Reset (rst_n low, async):
- FSM goes to IDLE.
- stall=0, bubble_exe=0, hazard=0, fwd_data=0, stall_cycles=0.

Writeback class by opcode:
- ALU: OP, OP-IMM, LUI, AUIPC; value is alu_out.
- LINK: JAL, JALR; value is pc_exe+4 in EXE, pc_4_acc in ACC.
- LOAD: value is dmem_out_acc in ACC only.
- NONE: branch, store, all other opcodes.

Source usage in DE:
- rs1 is used unless the opcode is LUI, AUIPC or JAL.
- rs2 is used only for OP, STORE and BRANCH.

Match rule:
- A producer matches when its slot is valid, its class is not NONE, rd != 0, and rd equals a used source in DE with valid_de=1.
- EXE has priority over ACC for each operand independently; operands are evaluated in parallel, with no else-if chaining.

Load-use:
- An EXE producer of class LOAD that matches any operand raises stall combinationally in IDLE.
- On the next edge the FSM moves to LD_WAIT and bubble_exe is registered as 1.

LD_WAIT:
- stall=1 while dmem_valid_acc=0, and bubble_exe stays 1.
- On the cycle dmem_valid_acc=1, stall=0.
- At that edge: hazard bit is set and fwd_data=dmem_out_acc for each matching operand; the FSM returns to IDLE.

Forward timing:
- At each edge where stall=0, hazard and fwd_data are loaded from the current match results (EXE value or ACC value).
- Non-matching bits of hazard are 0 and their fwd_data lanes hold the previous value.
- When stall=1, hazard is held at 0.

Flush:
- Flush has priority over everything.
- stall=0 combinationally.
- At the edge: FSM goes to IDLE, hazard=0, bubble_exe=1.
- A simultaneous load-use is discarded.

Counter:
- stall_cycles increments on each edge with stall=1 and saturates at all-ones.

Single-cycle latency, EXE to consumer:
- No stall for ALU or LINK producers; the EXE value is sampled at the edge.

Decomposition:
- Package rv32_pkg: opcode localparams (OP, OP_IMM, LUI, AUIPC, JAL, JALR, LOAD, STORE, BRANCH), wb class enum (WB_NONE, WB_ALU, WB_LINK, WB_LOAD), FSM state enum (IDLE, LD_WAIT).
- Sub-module src_match: one per operand via generate. Inputs are the source register, the used flag and both producer tuples; outputs are hit, sel_exe and load_hit.

Test Plan:
1. addi x5,x0,7 in EXE (alu_out_exe=7), add x6,x5,x5 in DE -> stall=0; next cycle hazard=2'b11, both fwd_data lanes=7.
2. lw x3 in EXE, sub x4,x3,x1 in DE; dmem_valid_acc low 2 cycles, then 0xDEADBEEF -> stall=1 for 3 cycles, bubble_exe=1 for those cycles; then hazard=2'b01, lane0=0xDEADBEEF, stall_cycles=3.
3. Same rd=x8 in EXE (alu 0x10) and ACC (alu 0x20), DE reads x8 -> fwd_data=0x10 (EXE priority).
4. jal x1 in ACC (pc_4_acc=0x104), DE sw reads x1 as rs2 -> hazard=2'b10, lane1=0x104; producer with rd=x0 -> hazard=0.
5. Load-use stall in progress, flush=1 -> stall=0 same cycle; next cycle FSM IDLE, hazard=0, bubble_exe=1.
6. Assert rst_n low mid-LD_WAIT -> all outputs 0 immediately; stall_cycles=0.
